// File: rtl/cs_decoder_arbiter.sv
// cs_decoder_arbiter: round-robin arbiter sharing one 74138-style 3-to-8
// decoder between 8 requesters. S is loaded only in IDLE and the decoder is
// enabled only in GRANT, so S never moves while chip selects are live.
// Optional forced release after MAX_HOLD grant cycles when the macro
// CS_DECODER_ARBITER_TIMEOUT_EN is defined; otherwise timeout is tied low.
module cs_decoder_arbiter #(
   parameter int N_REQ    = 8,
   parameter int MAX_HOLD = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] done,
   output logic [2:0]       S,
   output logic [2:0]       I,
   output logic [N_REQ-1:0] gnt,
   output logic             busy,
   output logic             timeout
);

   typedef enum logic [1:0] {IDLE, SETUP, GRANT, RELEASE} state_t;

   // Elaboration guards: select bus is 3 bits and the hold counter is 8 bits.
   if (N_REQ != 8) begin : g_bad_nreq
      $error("cs_decoder_arbiter: N_REQ must be 8");
   end
   if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
      $error("cs_decoder_arbiter: MAX_HOLD must be 1..255");
   end

   state_t     state_q, state_d;
   logic [2:0] s_q, s_d;
   logic [2:0] ptr_q, ptr_d;
   logic [2:0] win;

`ifdef CS_DECODER_ARBITER_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
   logic [7:0] hold_q, hold_d;
   logic       to_q, to_d;
`endif

   // Round-robin winner: first requester at or after ptr+1, wrapping 7->0.
   always_comb begin
      logic       found;
      logic [2:0] idx;
      win   = ptr_q;
      found = 1'b0;
      for (int unsigned k = 1; k <= 8; k++) begin
         idx = ptr_q + 3'(k);
         if (!found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

   // Next-state logic: IDLE picks, SETUP settles S, GRANT holds, RELEASE rotates.
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      ptr_d   = ptr_q;
`ifdef CS_DECODER_ARBITER_TIMEOUT_EN
      hold_d  = hold_q;
      to_d    = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (req != '0) begin
               s_d     = win;
               state_d = SETUP;
            end
         end
         SETUP: begin
            state_d = GRANT;
`ifdef CS_DECODER_ARBITER_TIMEOUT_EN
            hold_d  = '0;
`endif
         end
         GRANT: begin
            if (done[s_q] || !req[s_q]) begin
               state_d = RELEASE;
`ifdef CS_DECODER_ARBITER_TIMEOUT_EN
            end else if (hold_q == HOLD_LAST) begin
               state_d = RELEASE;
               to_d    = 1'b1;
            end else begin
               hold_d  = hold_q + 8'd1;
`endif
            end
         end
         RELEASE: begin
            ptr_d   = s_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         s_q     <= 3'd0;
         ptr_q   <= 3'd7;
`ifdef CS_DECODER_ARBITER_TIMEOUT_EN
         hold_q  <= '0;
         to_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         ptr_q   <= ptr_d;
`ifdef CS_DECODER_ARBITER_TIMEOUT_EN
         hold_q  <= hold_d;
         to_q    <= to_d;
`endif
      end
   end

   // Outputs decoded from registered state only, so they cannot glitch.
   always_comb begin
      S    = s_q;
      I    = (state_q == GRANT) ? 3'b100 : 3'b011;
      gnt  = '0;
      if (state_q == GRANT) gnt[s_q] = 1'b1;
      busy = (state_q != IDLE);
`ifdef CS_DECODER_ARBITER_TIMEOUT_EN
      timeout = to_q;
`else
      timeout = 1'b0;
`endif
   end

endmodule

// File: tb/tb_cs_decoder_arbiter.sv
// Self-checking bench for cs_decoder_arbiter: a transaction-level model
// (owner, age of current transaction, release flag) is checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_cs_decoder_arbiter;

`ifdef CS_DECODER_ARBITER_TIMEOUT_EN
   localparam int MH = 4;
`else
   localparam int MH = 16;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] req, done;
   logic [2:0] S, I;
   logic [7:0] gnt;
   logic       busy, timeout;

   int checks = 0;
   int errors = 0;

   cs_decoder_arbiter #(.N_REQ(8), .MAX_HOLD(MH)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .done(done),
      .S(S), .I(I), .gnt(gnt), .busy(busy), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_owner;   // requester currently (or last) selected
   int m_age;     // 0 = no transaction, 1 = select settling, >=2 = decoder enabled
   bit m_rel;     // transaction is in its closing cycle
   int m_ptr;     // last requester served
   bit m_to;

   function automatic int pick(input logic [7:0] r, input int p);
      for (int k = 1; k <= 8; k++)
         if (r[(p + k) % 8]) return (p + k) % 8;
      return p;
   endfunction

   task automatic model_step();
      if (!rst_n) begin
         m_owner = 0; m_age = 0; m_rel = 0; m_ptr = 7; m_to = 0;
      end else if (m_rel) begin
         m_rel = 0; m_to = 0; m_ptr = m_owner;
      end else if (m_age == 0) begin
         if (req != 8'h00) begin
            m_owner = pick(req, m_ptr);
            m_age = 1;
         end
      end else if (m_age == 1) begin
         m_age = 2;
      end else begin
         if (done[m_owner] || !req[m_owner]) begin
            m_age = 0; m_rel = 1;
`ifdef CS_DECODER_ARBITER_TIMEOUT_EN
         end else if (m_age - 2 == MH - 1) begin
            m_age = 0; m_rel = 1; m_to = 1;
`endif
         end else begin
            m_age++;
         end
      end
   endtask

   // Single compare process: advance the model on each edge, then check.
   always @(posedge clk) begin
      model_step();
      #1;
      chk("m_S", 32'(S), 32'(m_owner));
      chk("m_I", 32'(I), (m_age >= 2) ? 32'd4 : 32'd3);
      chk("m_gnt", 32'(gnt), (m_age >= 2) ? (32'd1 << m_owner) : 32'd0);
      chk("m_busy", 32'(busy), 32'(m_age != 0 || m_rel));
      chk("m_timeout", 32'(timeout), 32'(m_to));
   end

   // ---------------- directed + random stimulus ----------------
   task automatic cyc(); @(negedge clk); endtask

   task automatic wait_grant(input string name, output bit ok);
      ok = 0;
      for (int k = 0; k < 40; k++) begin
         if (I == 3'b100) begin ok = 1; break; end
         cyc();
      end
      if (!ok) chk({name, "_bound"}, 32'd0, 32'd1);
   endtask

   task automatic do_reset(input int n);
      rst_n = 0;
      repeat (n) cyc();
      rst_n = 1;
   endtask

   initial begin
      bit ok;
      int seq[$];
      int cnt;
      rst_n = 0; req = 8'hFF; done = 8'h00;

      // Reset holds outputs idle even with everyone requesting.
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("rst_S", 32'(S), 32'd0);
         chk("rst_I", 32'(I), 32'd3);
         chk("rst_gnt", 32'(gnt), 32'd0);
         chk("rst_busy", 32'(busy), 32'd0);
      end
      rst_n = 1;
      cyc(); cyc();
      chk("first_gnt", 32'(gnt), 32'h01);

      // Round robin, done asserted whenever granted.
      done = 8'hFF;
      seq.delete();
      while (seq.size() < 9) begin
         wait_grant("rr", ok);
         if (!ok) break;
         seq.push_back(int'(S));
         cyc();
      end
      foreach (seq[i]) chk("rr_seq", 32'(seq[i]), 32'(i % 8));

      // Wrap and skip: serve 6, then 0,1,6 follow.
      req = 8'h40;
      for (int k = 0; k < 6; k++) begin
         wait_grant("wrap6", ok);
         if (!ok || S == 3'd6) break;
         cyc();
      end
      chk("wrap_pre", 32'(S), 32'd6);
      req = 8'b0100_0011;
      cyc();
      seq.delete();
      while (seq.size() < 3) begin
         wait_grant("wrap", ok);
         if (!ok) break;
         seq.push_back(int'(S));
         cyc();
      end
      if (seq.size() == 3) begin
         chk("wrap0", 32'(seq[0]), 32'd0);
         chk("wrap1", 32'(seq[1]), 32'd1);
         chk("wrap2", 32'(seq[2]), 32'd6);
      end

      // Single request with done three cycles after grant entry.
      req = 8'h00; done = 8'h00;
      do_reset(2);
      req = 8'h20;
      cyc();
      chk("single_setup_S", 32'(S), 32'd5);
      chk("single_setup_I", 32'(I), 32'd3);
      chk("single_setup_busy", 32'(busy), 32'd1);
      cyc();
      chk("single_grant_I", 32'(I), 32'd4);
      chk("single_grant_gnt", 32'(gnt), 32'h20);
      cyc(); cyc(); cyc();
      done = 8'h20;
      cyc();
      done = 8'h00;
      chk("single_rel_I", 32'(I), 32'd3);
      chk("single_rel_busy", 32'(busy), 32'd1);
      cyc();
      chk("single_idle_busy", 32'(busy), 32'd0);
      cyc();
      chk("regrant_S", 32'(S), 32'd5);
      cyc();
      chk("regrant_gnt", 32'(gnt), 32'h20);

      // Request dropped during SETUP: one GRANT cycle then RELEASE.
      req = 8'h00;
      cyc(); cyc();
      req = 8'h02;
      cyc();
      chk("drop_setup_S", 32'(S), 32'd1);
      req = 8'h00;
      cyc();
      chk("drop_gnt", 32'(gnt), 32'h02);
      cyc();
      chk("drop_rel_I", 32'(I), 32'd3);
      chk("drop_rel_busy", 32'(busy), 32'd1);

      // Reset mid-grant clears immediately and restores ptr to 7.
      cyc();
      req = 8'h08;
      wait_grant("midrst", ok);
      chk("midrst_gnt", 32'(gnt), 32'h08);
      rst_n = 0;
      cyc();
      chk("midrst_I", 32'(I), 32'd3);
      chk("midrst_gnt0", 32'(gnt), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      rst_n = 1; req = 8'hFF;
      cyc(); cyc();
      chk("midrst_ptr", 32'(gnt), 32'h01);

      // Hold behaviour with done never asserted.
      req = 8'h00; done = 8'h00;
      do_reset(1);
      req = 8'h04;
      wait_grant("hold", ok);
      cnt = 0;
      for (int k = 0; k < 60 && I == 3'b100; k++) begin
         cnt++;
         if (timeout) break;
         cyc();
      end
`ifdef CS_DECODER_ARBITER_TIMEOUT_EN
      chk("to_cycles", 32'(cnt), 32'd4);
      chk("to_pulse", 32'(timeout), 32'd1);
      chk("to_I", 32'(I), 32'd3);
      cyc();
      chk("to_width", 32'(timeout), 32'd0);
`else
      chk("hold_long", 32'(cnt >= 50), 32'd1);
      chk("hold_to", 32'(timeout), 32'd0);
`endif
      req = 8'h00;
      cyc(); cyc(); cyc();

      // Random traffic, model-checked every cycle.
      for (int k = 0; k < 3000; k++) begin
         req  = 8'($urandom) & 8'($urandom) | 8'($urandom_range(0, 1) ? $urandom : 0);
         done = 8'($urandom) & 8'($urandom) & 8'($urandom);
         rst_n = ($urandom_range(0, 199) != 0);
         cyc();
      end
      rst_n = 1; req = 8'h00; done = 8'h00;
      cyc(); cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
